inst_trace_buffer: RTL

- Parametrised retire-trace capture block for the RISC core; replaces ad-hoc per-cycle register printing in the processor bench.
- Records each writeback-stage instruction with its PC and a cycle stamp into a circular buffer, drained through a valid/ready port.
- Tracks cycle and retire counts, detects halt, and runs a no-retire watchdog.
- Synthesisable so it can sit beside the core in both RTL and netlist simulation.

---
 rtl/inst_trace_buffer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/inst_trace_buffer.sv
// inst_trace_buffer: retire-trace capture for the RISC core. Writeback-stage
//   instructions are stamped with the RUN cycle count and stored in a circular
//   buffer that is drained through a first-word-fall-through valid/ready port.
// Latency: a captured entry is visible on rd_* the cycle after wb_valid; reads are combinational.
// Backpressure: rd_ready stalls the head; when full, new retirements are dropped
//   (or, with TRACE_OVERWRITE_EN defined, evict the oldest) and overflow is set.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   trace_en              arm/run capture; low returns to IDLE
//   wb_valid/inst/pc      retiring instruction from writeback
//   halt                  core halt level; ends capture
//   rd_ready/valid/inst/pc/stamp  head entry read port
//   count, overflow       occupancy and sticky lost-entry flag
//   cycle_cnt, retire_cnt RUN cycle and retirement counters (saturating)
//   timeout, done         sticky watchdog trip, DONE-state indicator
//
// Optional macro: TRACE_OVERWRITE_EN (overwrite-oldest on full instead of drop-newest).

module inst_trace_buffer #(
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = 1000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       trace_en,
  input  logic                       wb_valid,
  input  logic [INST_WIDTH-1:0]      wb_inst,
  input  logic [PC_WIDTH-1:0]        wb_pc,
  input  logic                       halt,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [INST_WIDTH-1:0]      rd_inst,
  output logic [PC_WIDTH-1:0]        rd_pc,
  output logic [CNT_WIDTH-1:0]       rd_stamp,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [CNT_WIDTH-1:0]       cycle_cnt,
  output logic [CNT_WIDTH-1:0]       retire_cnt,
  output logic                       timeout,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [CW-1:0]        DEPTH_C   = CW'(DEPTH);

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [PC_WIDTH-1:0]   pc;
    logic [CNT_WIDTH-1:0]  stamp;
  } entry_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  entry_t               mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CNT_WIDTH-1:0] wd_cnt;

  logic                 capture;
  logic                 pop;
  logic                 full;
  logic                 do_write;
  logic                 evict;
  logic                 lost;
  logic [CW-1:0]        count_nxt;
  logic [CNT_WIDTH-1:0] cycle_inc;
  logic [CNT_WIDTH-1:0] retire_inc;
  logic [CNT_WIDTH-1:0] wd_inc;
  logic                 wd_trip;

  assign rd_valid = (count != '0);
  assign rd_inst  = mem[rd_ptr].inst;
  assign rd_pc    = mem[rd_ptr].pc;
  assign rd_stamp = mem[rd_ptr].stamp;

  always_comb begin
    capture = (state == RUN) && wb_valid;
    pop     = rd_valid && rd_ready;
    full    = (count == DEPTH_C);
`ifdef TRACE_OVERWRITE_EN
    // Full with no pop: the new entry replaces the oldest, so the read
    // pointer steps along with the write pointer.
    do_write = capture;
    evict    = capture && full && !pop;
    lost     = evict;
`else
    // Full with no pop: drop the newest retirement.
    do_write = capture && (!full || pop);
    evict    = 1'b0;
    lost     = capture && full && !pop;
`endif
    count_nxt = count;
    if (do_write && !pop && !evict) count_nxt = count + 1'b1;
    else if (pop && !do_write)      count_nxt = count - 1'b1;

    cycle_inc  = (cycle_cnt  == CNT_MAX) ? cycle_cnt  : cycle_cnt  + 1'b1;
    retire_inc = (retire_cnt == CNT_MAX) ? retire_cnt : retire_cnt + 1'b1;
    wd_inc     = (wd_cnt     == CNT_MAX) ? wd_cnt     : wd_cnt     + 1'b1;
    // Trips on the cycle that completes TIMEOUT consecutive idle RUN cycles.
    wd_trip    = !wb_valid && (wd_inc >= TIMEOUT_C);
  end

  // Storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= entry_t'{inst: wb_inst, pc: wb_pc, stamp: cycle_cnt};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      wd_cnt     <= '0;
      timeout    <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (do_write)     wr_ptr <= wr_ptr + 1'b1;
      if (pop || evict) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      if (lost) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (trace_en) begin
            state      <= RUN;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            wd_cnt     <= '0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        RUN: begin
          cycle_cnt <= cycle_inc;
          if (wb_valid) retire_cnt <= retire_inc;
          wd_cnt <= wb_valid ? '0 : wd_inc;
          if (!trace_en) begin
            state <= IDLE;
          end else if (halt) begin
            state <= DRAIN;
          end else if (wd_trip) begin
            state   <= DRAIN;
            timeout <= 1'b1;
          end
        end
        DRAIN: begin
          if (!trace_en) begin
            state <= IDLE;
          end else if (count == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!trace_en) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
